// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative multiply/divide unit that owns the architectural HI/LO pair.
//   MULT/MULTU/DIV/DIVU run as 34-cycle operations (32 iterations, one
//   fixup cycle, then the result is visible with a one-cycle done pulse).
//   MTHI/MTLO write HI/LO in a single cycle.
//
// Ports
//   clk     in   1  system clock, rising-edge
//   reset   in   1  synchronous active-high reset
//   start   in   1  instruction-present strobe
//   fncode  in   6  R-type funct field
//   op_a    in  32  rs value (multiplicand / dividend / MTHI-MTLO data)
//   op_b    in  32  rt value (multiplier / divisor)
//   busy    out  1  multi-cycle operation in flight
//   done    out  1  one-cycle pulse, HI/LO hold the new result
//   hi      out 32  HI register
//   lo      out 32  LO register
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  fncode,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        is_div_reg;
  logic        neg_q_reg;
  logic        neg_r_reg;
  logic [4:0]  count_reg;
  // acc_hi/acc_lo are the product halves during MUL and the
  // remainder/quotient during DIV; opnd is the multiplicand or divisor.
  logic [31:0] acc_hi_reg;
  logic [31:0] acc_lo_reg;
  logic [31:0] opnd_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        busy_reg;
  logic        done_reg;

  // ---------------- decode of the incoming instruction ----------------
  logic        dec_mul;
  logic        dec_div;
  logic        dec_signed;
  logic        div_zero;
  logic        use_abs;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  always_comb begin
    dec_mul    = (fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU);
    dec_div    = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
    dec_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    div_zero   = dec_div && (op_b == 32'd0);
    // For a zero divisor the raw dividend is latched with no sign flags:
    // restoring division by 0 then leaves quotient all-ones and the
    // remainder equal to the original op_a, with no fixup needed.
    use_abs    = dec_signed && !div_zero;
    a_mag      = (use_abs && op_a[31]) ? (32'd0 - op_a) : op_a;
    b_mag      = (use_abs && op_b[31]) ? (32'd0 - op_b) : op_b;
  end

  // ---------------- FSM next state / control strobes ----------------
  logic start_mul;
  logic start_div;
  logic wr_hi;
  logic wr_lo;

  always_comb begin
    state_next = state_reg;
    start_mul  = 1'b0;
    start_div  = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (dec_mul) begin
            start_mul  = 1'b1;
            state_next = MUL;
          end else if (dec_div) begin
            start_div  = 1'b1;
            state_next = DIV;
          end else if (fncode == FUNCT_MTHI) begin
            wr_hi = 1'b1;
          end else if (fncode == FUNCT_MTLO) begin
            wr_lo = 1'b1;
          end
        end
      end
      MUL, DIV: begin
        if (count_reg == 5'd0) begin
          state_next = FIXUP;
        end
      end
      FIXUP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- iteration datapath ----------------
  // Shift-add step: 33-bit sum keeps the carry, which becomes the new
  // top bit after the right shift of the 65-bit value.
  logic [32:0] mul_sum;
  // Restoring-division step on the left-shifted 33-bit remainder.
  logic [32:0] div_sh;
  logic        div_ok;
  // Sign fixup of the final product.
  logic [63:0] prod;
  logic [63:0] prod_fix;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : 33'd0);
    div_sh   = {acc_hi_reg, acc_lo_reg[31]};
    div_ok   = (div_sh >= {1'b0, opnd_reg});
    prod     = {acc_hi_reg, acc_lo_reg};
    prod_fix = neg_q_reg ? (64'd0 - prod) : prod;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      count_reg  <= 5'd0;
      acc_hi_reg <= 32'd0;
      acc_lo_reg <= 32'd0;
      opnd_reg   <= 32'd0;
      hi_reg     <= 32'd0;
      lo_reg     <= 32'd0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      busy_reg <= (state_next != IDLE);
      done_reg <= (state_reg == FIXUP);

      if (start_mul || start_div) begin
        is_div_reg <= start_div;
        neg_q_reg  <= use_abs && (op_a[31] ^ op_b[31]);
        neg_r_reg  <= use_abs && op_a[31];
        count_reg  <= 5'd31;
        acc_hi_reg <= 32'd0;
        // MUL: acc_lo holds the multiplier, opnd the multiplicand.
        // DIV: acc_lo holds the dividend (becomes quotient), opnd the divisor.
        acc_lo_reg <= start_div ? a_mag : b_mag;
        opnd_reg   <= start_div ? b_mag : a_mag;
      end

      if (wr_hi) begin
        hi_reg <= op_a;
      end
      if (wr_lo) begin
        lo_reg <= op_a;
      end

      case (state_reg)
        MUL: begin
          count_reg  <= count_reg - 5'd1;
          acc_hi_reg <= mul_sum[32:1];
          acc_lo_reg <= {mul_sum[0], acc_lo_reg[31:1]};
        end
        DIV: begin
          count_reg  <= count_reg - 5'd1;
          // When the trial subtract succeeds the true difference is below
          // the divisor, so 32-bit wrap-around subtraction is exact.
          acc_hi_reg <= div_ok ? (div_sh[31:0] - opnd_reg) : div_sh[31:0];
          acc_lo_reg <= {acc_lo_reg[30:0], div_ok};
        end
        FIXUP: begin
          if (is_div_reg) begin
            lo_reg <= neg_q_reg ? (32'd0 - acc_lo_reg) : acc_lo_reg;
            hi_reg <= neg_r_reg ? (32'd0 - acc_hi_reg) : acc_hi_reg;
          end else begin
            hi_reg <= prod_fix[63:32];
            lo_reg <= prod_fix[31:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
